// File: rtl/tx_pkg.sv
// Shared types and constants for the transducer fire sequencer.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MARK    = 3'd2,
    FIRE    = 3'd3,
    RELEASE = 3'd4,
    GAP     = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam int ARM_CYC  = 2;
  localparam int MARK_CYC = 2;
  localparam int TX_PD_W  = 16;
  localparam int TX_CT_W  = 9;

endpackage

// File: rtl/transducer_fire_sequencer_if.sv
// Channel-side bus between the sequencer (master) and the per-channel output stages (slave).
interface transducer_fire_sequencer_if
  import tx_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int PD_W = TX_PD_W,
    parameter int CT_W = TX_CT_W
);
    logic [N_CH-1:0]      ch_active;
    logic                 ch_rst;
    logic                 ch_mark;
    logic                 ch_go;
    logic [N_CH*PD_W-1:0] ch_pd;
    logic [CT_W-1:0]      ch_ct;
    logic [N_CH-1:0]      ch_fire_done;
    logic [N_CH-1:0]      ch_warn;

    modport master (
        output ch_active, ch_rst, ch_mark, ch_go, ch_pd, ch_ct,
        input  ch_fire_done, ch_warn
    );

    modport slave (
        input  ch_active, ch_rst, ch_mark, ch_go, ch_pd, ch_ct,
        output ch_fire_done, ch_warn
    );
endinterface

// File: rtl/tx_pd_regfile.sv
// Per-channel phase-delay registers with a single write port and a flat read bus.
module tx_pd_regfile
  import tx_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int PD_W = TX_PD_W,
    parameter int AW   = $clog2(N_CH)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [PD_W-1:0]      wdata,
    output logic [N_CH*PD_W-1:0] rdata
);

    // Out-of-range addresses simply match no lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (int'(addr) == i) rdata[i*PD_W +: PD_W] <= wdata;
            end
        end
    end

endmodule

// File: rtl/transducer_fire_sequencer.sv
// Sequences the per-channel arm/mark/fire/release cycle for a programmed number of fires,
// watching channel completion and warnings and latching a sticky fault.
module transducer_fire_sequencer
  import tx_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int PD_W  = TX_PD_W,
    parameter int CT_W  = TX_CT_W,
    parameter int TMO_W = 18,
    parameter int IV_W  = 24
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_addr,
    input  logic [PD_W-1:0]         cfg_pd,
    input  logic [CT_W-1:0]         charge_time,
    input  logic [N_CH-1:0]         ch_enable,
    input  logic [15:0]             num_fires,
    input  logic [IV_W-1:0]         interval,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    clear_fault,
    transducer_fire_sequencer_if.master ch,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic [N_CH-1:0]         fault_ch,
    output logic [15:0]             fires_left
);

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_t          st, st_n;
    logic [IV_W-1:0] cnt, cnt_n, iv;
    logic [TMO_W-1:0] tmo, tmo_n;
    logic [15:0]     fl_n;
    logic [N_CH-1:0] fch_n, warn_hit, pend;
    logic            fault_n, done_n, latch;

    tx_pd_regfile #(.N_CH(N_CH), .PD_W(PD_W)) u_pd (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && !busy),
        .addr  (cfg_addr),
        .wdata (cfg_pd),
        .rdata (ch.ch_pd)
    );

    // Disabled channels never hold up completion and never raise a fault.
    assign warn_hit = ch.ch_warn & ch.ch_active;
    assign pend     = ch.ch_active & ~ch.ch_fire_done;

    always_ff @(posedge clk) begin
        if (!rst) st <= IDLE;
        else      st <= st_n;
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        tmo_n   = tmo;
        fl_n    = fires_left;
        fault_n = fault;
        fch_n   = fault_ch;
        done_n  = 1'b0;
        latch   = 1'b0;
        if (st == IDLE) begin
            if (start) begin
                latch = 1'b1;
                fl_n  = num_fires;
                cnt_n = '0;
                if (num_fires != '0) st_n = ARM;
                else                 done_n = 1'b1;
            end
        end else if (abort) begin
            st_n    = IDLE;
            fault_n = 1'b0;
            fch_n   = '0;
        end else if (st == FAULT) begin
            if (clear_fault) begin
                st_n    = IDLE;
                fault_n = 1'b0;
                fch_n   = '0;
            end
        end else if (warn_hit != '0) begin
            st_n    = FAULT;
            fault_n = 1'b1;
            fch_n   = warn_hit;
        end else if (st == FIRE && pend != '0 && tmo == TMO_MAX - TMO_W'(1)) begin
            st_n    = FAULT;
            fault_n = 1'b1;
            fch_n   = pend;
        end else begin
            case (st)
                ARM: begin
                    if (cnt == IV_W'(ARM_CYC - 1)) begin
                        st_n  = MARK;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + IV_W'(1);
                    end
                end
                MARK: begin
                    if (cnt == IV_W'(MARK_CYC - 1)) begin
                        st_n  = FIRE;
                        cnt_n = '0;
                        tmo_n = '0;
                    end else begin
                        cnt_n = cnt + IV_W'(1);
                    end
                end
                FIRE: begin
                    if (pend == '0) begin
                        if (fires_left != '0) fl_n = fires_left - 16'd1;
                        st_n = RELEASE;
                    end else if (tmo != TMO_MAX) begin
                        tmo_n = tmo + TMO_W'(1);
                    end
                end
                RELEASE: begin
                    cnt_n = '0;
                    if (fires_left != '0) begin
                        st_n = (iv == '0) ? ARM : GAP;
                    end else begin
                        st_n   = IDLE;
                        done_n = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == iv - IV_W'(1)) begin
                        st_n  = ARM;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + IV_W'(1);
                    end
                end
                default: st_n = IDLE;
            endcase
        end
    end

    // Channel strobes are registered from the next state so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            tmo          <= '0;
            iv           <= '0;
            fires_left   <= '0;
            fault        <= 1'b0;
            fault_ch     <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            ch.ch_active <= '0;
            ch.ch_ct     <= '0;
            ch.ch_rst    <= 1'b1;
            ch.ch_mark   <= 1'b0;
            ch.ch_go     <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            tmo        <= tmo_n;
            fires_left <= fl_n;
            fault      <= fault_n;
            fault_ch   <= fch_n;
            done       <= done_n;
            if (latch) begin
                ch.ch_active <= ch_enable;
                ch.ch_ct     <= charge_time;
                iv           <= interval;
            end
            busy       <= !(st_n inside {IDLE, FAULT});
            ch.ch_rst  <= st_n inside {IDLE, ARM, RELEASE, FAULT};
            ch.ch_mark <= st_n inside {MARK, FIRE};
            ch.ch_go   <= (st_n == FIRE);
        end
    end

endmodule

// File: tb/tb_transducer_fire_sequencer.sv
// Randomized bench for transducer_fire_sequencer: channel models plus an expected per-cycle trace.
module tb_transducer_fire_sequencer;

    localparam int N  = 8;
    localparam int TW = 8;
    localparam int TMO_CYC = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_pd;
    logic [8:0]  charge_time;
    logic [7:0]  ch_enable;
    logic [15:0] num_fires;
    logic [23:0] interval;
    logic        start, abort, clear_fault;
    logic        busy, done, fault;
    logic [7:0]  fault_ch;
    logic [15:0] fires_left;
    logic [7:0]  fdone = '0;
    logic [7:0]  warn;

    int total = 0;
    int bad   = 0;
    int dly [N];
    int gcnt [N];
    logic [15:0] pd_m [N];
    logic [20:0] exp_q [$];

    transducer_fire_sequencer_if #(.N_CH(N), .PD_W(16), .CT_W(9)) chif ();

    assign chif.ch_fire_done = fdone;
    assign chif.ch_warn      = warn;

    transducer_fire_sequencer #(.N_CH(N), .PD_W(16), .CT_W(9), .TMO_W(TW), .IV_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_pd      (cfg_pd),
        .charge_time (charge_time),
        .ch_enable   (ch_enable),
        .num_fires   (num_fires),
        .interval    (interval),
        .start       (start),
        .abort       (abort),
        .clear_fault (clear_fault),
        .ch          (chif),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_ch    (fault_ch),
        .fires_left  (fires_left)
    );

    always #5 clk = ~clk;

    // Channel i raises fireComplete after dly[i] GO cycles (0 = never); reset clears it.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (chif.ch_rst === 1'b1) begin
                gcnt[i]  = 0;
                fdone[i] = 1'b0;
            end else if (chif.ch_go === 1'b1) begin
                gcnt[i]++;
                if (dly[i] != 0 && gcnt[i] >= dly[i]) fdone[i] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pd_flat();
        logic [127:0] v;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = pd_m[i];
        return v;
    endfunction

    task automatic push(input int n, input logic r, input logic mk, input logic g,
                        input logic b, input logic d, input int fl);
        repeat (n) exp_q.push_back({r, mk, g, b, d, 16'(fl)});
    endtask

    task automatic start_run(input int f, input int iv, input logic [7:0] m, input logic [8:0] ct);
        num_fires = 16'(f); interval = 24'(iv); ch_enable = m; charge_time = ct;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++;
        if ({chif.ch_active, chif.ch_rst, chif.ch_mark, chif.ch_go, chif.ch_ct} !== {8'h00, 1'b1, 1'b0, 1'b0, 9'h0}) begin
            bad++; $display("FAIL reset_ch: got %h", {chif.ch_active, chif.ch_rst, chif.ch_mark, chif.ch_go, chif.ch_ct});
        end
        total++;
        if ({busy, done, fault, fault_ch, fires_left} !== 27'h0) begin
            bad++; $display("FAIL reset_host: got %h want 0", {busy, done, fault, fault_ch, fires_left});
        end
        total++;
        if (chif.ch_pd !== 128'h0) begin bad++; $display("FAIL reset_pd: got %h want 0", chif.ch_pd); end
        rst = 1'b1;
        tick();
        total++;
        if ({chif.ch_rst, busy} !== 2'b10) begin bad++; $display("FAIL reset_idle: got %b want 10", {chif.ch_rst, busy}); end
    endtask

    task automatic test_run(input int f, input int iv, input logic [7:0] m, input logic [8:0] ct, input bit fixed_pd);
        int l, bad_at, dcnt;
        logic [20:0] got, got_b, exp_b;
        for (int i = 0; i < N; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i);
            cfg_pd = fixed_pd ? 16'(4 * i) : 16'($urandom);
            pd_m[i] = cfg_pd;
            tick();
        end
        cfg_we = 1'b0;
        l = 1;
        for (int i = 0; i < N; i++) begin
            dly[i] = $urandom_range(1, 6);
            if (m[i] && dly[i] > l) l = dly[i];
        end
        exp_q.delete();
        for (int k = 0; k < f; k++) begin
            push(2, 1, 0, 0, 1, 0, f - k);
            push(2, 0, 1, 0, 1, 0, f - k);
            push(l, 0, 1, 1, 1, 0, f - k);
            push(1, 1, 0, 0, 1, 0, f - k - 1);
            if (k < f - 1) push(iv, 0, 0, 0, 1, 0, f - k - 1);
        end
        push(1, 1, 0, 0, 0, 1, 0);
        push(2, 1, 0, 0, 0, 0, 0);
        // A write in the same cycle as start must still land.
        if (!fixed_pd) begin
            cfg_we = 1'b1; cfg_addr = 3'($urandom_range(0, 7)); cfg_pd = 16'($urandom);
            pd_m[cfg_addr] = cfg_pd;
        end
        start_run(f, iv, m, ct);
        cfg_we = 1'b0;
        total++;
        if ({chif.ch_active, chif.ch_ct} !== {m, ct}) begin
            bad++; $display("FAIL run_latch: got %h want %h", {chif.ch_active, chif.ch_ct}, {m, ct});
        end
        total++;
        if (chif.ch_pd !== pd_flat()) begin bad++; $display("FAIL run_pd: got %h want %h", chif.ch_pd, pd_flat()); end
        bad_at = -1; dcnt = 0; got_b = '0; exp_b = '0;
        foreach (exp_q[j]) begin
            got = {chif.ch_rst, chif.ch_mark, chif.ch_go, busy, done, fires_left};
            if (done === 1'b1) dcnt++;
            if (got !== exp_q[j] && bad_at < 0) begin bad_at = j; got_b = got; exp_b = exp_q[j]; end
            tick();
        end
        total++;
        if (bad_at >= 0) begin
            bad++; $display("FAIL run_trace f=%0d iv=%0d cycle %0d: got %h want %h", f, iv, bad_at, got_b, exp_b);
        end
        total++;
        if (dcnt !== 1) begin bad++; $display("FAIL run_done_count: got %0d want 1", dcnt); end
    endtask

    task automatic test_timeout();
        int c;
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 6);
        dly[2] = 0;
        start_run(1, 0, 8'hFF, 9'd7);
        for (c = 0; c < 20 && chif.ch_go !== 1'b1; c++) tick();
        c = 0;
        while (chif.ch_go === 1'b1 && c < 1000) begin c++; tick(); end
        total++;
        if (c !== TMO_CYC) begin bad++; $display("FAIL timeout_len: got %0d want %0d", c, TMO_CYC); end
        total++;
        if ({fault, fault_ch, busy, chif.ch_rst, chif.ch_mark, chif.ch_go} !== {1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL timeout_fault: got %h", {fault, fault_ch, busy, chif.ch_rst, chif.ch_mark, chif.ch_go});
        end
        start_run(2, 0, 8'hFF, 9'd7);
        total++;
        if ({busy, fault} !== 2'b01) begin bad++; $display("FAIL fault_start_ignored: got %b want 01", {busy, fault}); end
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        total++;
        if ({fault, fault_ch, busy} !== 10'h0) begin bad++; $display("FAIL timeout_clear: got %h want 0", {fault, fault_ch, busy}); end
    endtask

    task automatic test_warn();
        int c;
        for (int i = 0; i < N; i++) dly[i] = 0;
        start_run(2, 3, 8'hFF, 9'd20);
        for (c = 0; c < 20 && chif.ch_go !== 1'b1; c++) tick();
        tick(); tick();
        warn = 8'h20;
        tick();
        warn = 8'h00;
        total++;
        if ({fault, fault_ch, busy, chif.ch_go} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin
            bad++; $display("FAIL warn_fault: got %h want %h", {fault, fault_ch, busy, chif.ch_go}, {1'b1, 8'h20, 1'b0, 1'b0});
        end
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        total++;
        if ({fault, fault_ch, busy, chif.ch_rst} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            bad++; $display("FAIL warn_clear: got %h", {fault, fault_ch, busy, chif.ch_rst});
        end
    endtask

    task automatic test_abort();
        bit seen_done;
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 6);
        start_run(2, 1, 8'hFF, 9'd10);
        tick(); tick(); tick();
        total++;
        if ({chif.ch_mark, chif.ch_go, busy} !== 3'b101) begin
            bad++; $display("FAIL abort_pre_mark: got %b want 101", {chif.ch_mark, chif.ch_go, busy});
        end
        abort = 1'b1; tick(); abort = 1'b0;
        total++;
        if ({chif.ch_rst, chif.ch_mark, chif.ch_go, busy, done, fault} !== 6'b100000) begin
            bad++; $display("FAIL abort_idle: got %b want 100000", {chif.ch_rst, chif.ch_mark, chif.ch_go, busy, done, fault});
        end
        seen_done = 0;
        repeat (4) begin tick(); if (done === 1'b1 || busy !== 1'b0) seen_done = 1; end
        total++;
        if (seen_done) begin bad++; $display("FAIL abort_quiet: got activity after abort, want none"); end
    endtask

    task automatic test_fire_ignores();
        int c;
        bit seen_done;
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 6);
        dly[3] = 0;
        dly[0] = 4;
        start_run(1, 0, 8'hF7, 9'd3);
        for (c = 0; c < 20 && chif.ch_go !== 1'b1; c++) tick();
        total++;
        if (chif.ch_go !== 1'b1) begin bad++; $display("FAIL ign_reach_fire: got go=%b want 1", chif.ch_go); end
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_pd = ~pd_m[1]; warn = 8'h08;
        tick();
        cfg_we = 1'b0;
        total++;
        if (chif.ch_pd !== pd_flat()) begin bad++; $display("FAIL busy_write_dropped: got %h want %h", chif.ch_pd, pd_flat()); end
        seen_done = 0;
        for (c = 0; c < 30 && !seen_done; c++) begin if (done === 1'b1) seen_done = 1; else tick(); end
        warn = 8'h00;
        total++;
        if (!seen_done || fault !== 1'b0) begin
            bad++; $display("FAIL disabled_ignored: got done=%0d fault=%b want done=1 fault=0", seen_done, fault);
        end
        tick();
    endtask

    task automatic test_zero_fires();
        bit armed;
        start_run(0, 4, 8'h5A, 9'd9);
        total++;
        if ({done, busy, fires_left, chif.ch_active} !== {1'b1, 1'b0, 16'h0, 8'h5A}) begin
            bad++; $display("FAIL zero_done: got %h", {done, busy, fires_left, chif.ch_active});
        end
        armed = 0;
        repeat (4) begin tick(); if (busy !== 1'b0 || done !== 1'b0 || chif.ch_rst !== 1'b1) armed = 1; end
        total++;
        if (armed) begin bad++; $display("FAIL zero_no_arm: got activity, want idle"); end
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pd = '0; charge_time = '0;
        ch_enable = '0; num_fires = '0; interval = '0; start = 1'b0; abort = 1'b0;
        clear_fault = 1'b0; warn = '0;
        for (int i = 0; i < N; i++) begin dly[i] = 1; gcnt[i] = 0; pd_m[i] = '0; end
        test_reset();
        test_run(3, 5, 8'hFF, 9'd10, 1'b1);
        for (int r = 0; r < 4; r++)
            test_run($urandom_range(1, 4), $urandom_range(0, 6), 8'($urandom), 9'($urandom), 1'b0);
        test_timeout();
        test_warn();
        test_abort();
        test_run(2, 2, 8'hFF, 9'd12, 1'b0);
        test_fire_ignores();
        test_zero_fires();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
